// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder for the core load/store port
//
// One request at a time is served from an internal single-port synchronous
// word RAM. The RAM has no byte enables, so sub-word stores read the word,
// merge the new lane(s) in, then write the whole word back.
//
// Parameters:
//   ADDR_W    word-address width, depth = 2**ADDR_W 32-bit words
//   WAIT_CYC  extra RAM wait cycles after the read phase (0..15)
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   request handshake, ready only while idle
//   req_wr                1 = store, 0 = load
//   req_addr              byte address
//   req_type              000 b, 001 h, 010 w, 100 bu, 101 hu
//   req_wdata             store data, low byte/half used for sb/sh
//   rsp_valid/rsp_ready   response handshake, held until accepted
//   rsp_rdata             load result, 0 for stores and errors
//   rsp_err               request was rejected
//
// Optional build macro DMEM_PERF_CNT_EN adds saturating ld_cnt, st_cnt and
// err_cnt outputs counting completed loads, stores and errors.

module dmem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0] ld_cnt,
  output logic [15:0] st_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  logic [2:0]        state;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        type_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic              err_q;
  logic [3:0]        wait_cnt;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word;
  logic [ADDR_W-1:0] word_idx;

  logic              req_err;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic [2:0]        post_read_state;

  assign req_ready = (state == ST_IDLE);
  assign word_idx  = addr_q[ADDR_W+1:2];

  // Request qualification on the raw inputs so the IDLE edge can branch
  // straight to RESP for rejected accesses.
  always_comb begin
    req_err = 1'b0;
    case (req_type)
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      default: ;
    endcase
    // Unsigned variants have no store form.
    if (req_wr && req_type[2]) begin
      req_err = 1'b1;
    end
    if ((req_type[1:0] == 2'b01) && req_addr[0]) begin
      req_err = 1'b1;
    end
    if ((req_type == 3'b010) && (req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
    if ((req_addr >> (ADDR_W + 2)) != 32'd0) begin
      req_err = 1'b1;
    end
  end

  // Little-endian lane extraction from the registered RAM word.
  always_comb begin
    lane_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (type_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_data = {24'd0, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_data = {16'd0, lane_half};
      default: load_data = rd_word;
    endcase
  end

  // Read-modify-write merge of the store data into the word read earlier.
  always_comb begin
    merged_word = rd_word;
    case (type_q)
      3'b000: merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      3'b001: begin
        if (addr_q[1]) begin
          merged_word[31:16] = wdata_q[15:0];
        end else begin
          merged_word[15:0] = wdata_q[15:0];
        end
      end
      default: merged_word = wdata_q;
    endcase
  end

  // Loads are ready to respond once the RAM word is in hand; stores still
  // have the write cycle to do.
  assign post_read_state = wr_q ? ST_WRITE : ST_RESP;

  // RAM kept out of the reset domain: contents survive reset. Since reset
  // forces state to IDLE asynchronously, an interrupted store never
  // reaches a write edge.
  always_ff @(posedge clk) begin
    if (state == ST_WRITE) begin
      mem[word_idx] <= merged_word;
    end
    if (state == ST_READ) begin
      rd_word <= mem[word_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      type_q    <= 3'd0;
      wdata_q   <= 32'd0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      wait_cnt  <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[ADDR_W+1:0];
            type_q  <= req_type;
            wdata_q <= req_wdata;
            wr_q    <= req_wr;
            err_q   <= req_err;
            state   <= req_err ? ST_RESP : ST_READ;
          end
        end
        ST_READ: begin
          if (WAIT_CYC > 0) begin
            wait_cnt <= WAIT_LOAD;
            state    <= ST_WAIT;
          end else begin
            state <= post_read_state;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= post_read_state;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_WRITE: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          // First RESP cycle registers the response; afterwards it is held
          // until the initiator takes it.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            rsp_rdata <= (err_q || wr_q) ? 32'd0 : load_data;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_PERF_CNT_EN
  logic rsp_done;
  assign rsp_done = (state == ST_RESP) && rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt  <= 16'd0;
      st_cnt  <= 16'd0;
      err_cnt <= 16'd0;
    end else if (rsp_done) begin
      if (err_q) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else if (wr_q) begin
        if (st_cnt != 16'hFFFF) st_cnt <= st_cnt + 16'd1;
      end else begin
        if (ld_cnt != 16'hFFFF) ld_cnt <= ld_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
